// File: rtl/uart_clock_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_clock_rx
//  Purpose  : Receives 8N1 UART bytes and decodes the ASCII time line
//             "HH:MM:SS\r\n" into binary hours/minutes/seconds, with a
//             one-cycle strobe whenever the time outputs update.
//  Ports    : clk          - system clock (single clock domain)
//             reset        - synchronous, active-high reset
//             rx           - asynchronous UART line, idle high
//             hours        - last accepted hour (5 bit binary)
//             minutes      - last accepted minute (6 bit binary)
//             seconds      - last accepted second (6 bit binary)
//             time_valid   - one-cycle strobe when hours/minutes/seconds update
//             frame_error  - one-cycle strobe when a stop bit is sampled low
//             range_error  - one-cycle strobe when a line fails the range check
//  Options  : UART_CLOCK_RX_RANGE_CHECK_EN - when defined, completed lines with
//             hours > 23, minutes > 59 or seconds > 59 are rejected and flagged
//             on range_error; when undefined every well-formed line is accepted
//             and range_error is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_clock_rx #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       time_valid,
  output logic       frame_error,
  output logic       range_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser (resets to the idle line level)
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Byte receiver FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             w_byte_ok;
  logic             w_frame_err;
  logic             r_byte_valid;
  logic             r_frame_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_bit_idx     <= w_bit_next;
      r_shift       <= w_shift_next;
      r_byte_valid  <= w_byte_ok;
      r_frame_error <= w_frame_err;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_byte_ok    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A line still low after a frame error is taken as a fresh start bit.
        if (!r_sync2) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
          w_bit_next   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          // Line back high at mid start bit: it was a glitch.
          w_state_next = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_sync2, r_shift[7:1]};   // LSB arrives first
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
          if (r_sync2) begin
            w_byte_ok = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Line parser: template D D ':' D D ':' D D CR LF
  // --------------------------------------------------------------------------
  logic [3:0] r_idx;
  logic [3:0] r_h_t, r_h_o, r_m_t, r_m_o, r_s_t, r_s_o;
  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  logic       r_time_valid;
  logic       w_is_digit;
  logic       w_match;
  logic [3:0] w_digit;
  logic [4:0] w_hours;
  logic [5:0] w_minutes;
  logic [5:0] w_seconds;
  logic       w_line_ok;

  // The received byte stays in r_shift until the next frame's data bits.
  assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
  // For '0'..'9' the value byte - 0x30 equals the low nibble.
  assign w_digit    = r_shift[3:0];

  always_comb begin
    w_match = 1'b0;
    case (r_idx)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7: w_match = w_is_digit;
      4'd2, 4'd5:                         w_match = (r_shift == ASCII_COLON);
      4'd8:                               w_match = (r_shift == ASCII_CR);
      4'd9:                               w_match = (r_shift == ASCII_LF);
      default:                            w_match = 1'b0;
    endcase
  end

  // Arithmetic at output width truncates naturally (e.g. 99 hours -> 3).
  assign w_hours   = {1'b0, r_h_t} * 5'd10 + {1'b0, r_h_o};
  assign w_minutes = {2'b0, r_m_t} * 6'd10 + {2'b0, r_m_o};
  assign w_seconds = {2'b0, r_s_t} * 6'd10 + {2'b0, r_s_o};

`ifdef UART_CLOCK_RX_RANGE_CHECK_EN
  logic [6:0] w_hours_full;
  logic [6:0] w_minutes_full;
  logic [6:0] w_seconds_full;
  logic       r_range_error;

  assign w_hours_full   = {3'b0, r_h_t} * 7'd10 + {3'b0, r_h_o};
  assign w_minutes_full = {3'b0, r_m_t} * 7'd10 + {3'b0, r_m_o};
  assign w_seconds_full = {3'b0, r_s_t} * 7'd10 + {3'b0, r_s_o};
  assign w_line_ok      = (w_hours_full <= 7'd23) && (w_minutes_full <= 7'd59) &&
                          (w_seconds_full <= 7'd59);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_range_error <= 1'b0;
    end else begin
      r_range_error <= r_byte_valid && w_match && (r_idx == 4'd9) && !w_line_ok;
    end
  end

  assign range_error = r_range_error;
`else
  assign w_line_ok   = 1'b1;
  assign range_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_h_t        <= '0;
      r_h_o        <= '0;
      r_m_t        <= '0;
      r_m_o        <= '0;
      r_s_t        <= '0;
      r_s_o        <= '0;
      r_hours      <= '0;
      r_minutes    <= '0;
      r_seconds    <= '0;
      r_time_valid <= 1'b0;
    end else begin
      r_time_valid <= 1'b0;
      if (r_frame_error) begin
        r_idx <= '0;
      end else if (r_byte_valid) begin
        if (w_match) begin
          case (r_idx)
            4'd0:    r_h_t <= w_digit;
            4'd1:    r_h_o <= w_digit;
            4'd3:    r_m_t <= w_digit;
            4'd4:    r_m_o <= w_digit;
            4'd6:    r_s_t <= w_digit;
            4'd7:    r_s_o <= w_digit;
            default: ;
          endcase
          if (r_idx == 4'd9) begin
            r_idx <= '0;
            if (w_line_ok) begin
              r_hours      <= w_hours;
              r_minutes    <= w_minutes;
              r_seconds    <= w_seconds;
              r_time_valid <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end else begin
          // A mismatching byte is dropped, not retried as position 0.
          r_idx <= '0;
        end
      end
    end
  end

  assign hours       = r_hours;
  assign minutes     = r_minutes;
  assign seconds     = r_seconds;
  assign time_valid  = r_time_valid;
  assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_clock_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_clock_rx
//  Purpose  : Directed self-checking bench for uart_clock_rx. Sends complete
//             UART frames, counts output strobes and compares decoded time
//             against hand-computed values.
//  Options  : honours UART_CLOCK_RX_RANGE_CHECK_EN for the out-of-range line.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_clock_rx;

  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 240000;
  localparam int CPB      = CLK_FREQ / BAUD;          // 50 clocks per bit
  // Edges from rx falling to the stop-bit sample: 3 (two sync flops plus the
  // IDLE detect), half a bit, then nine full bits.
  localparam int LAT_FE   = 3 + CPB / 2 + 9 * CPB;    // 478
  localparam int LAT_TV   = LAT_FE + 1;               // 479

  logic       clk;
  logic       reset;
  logic       rx;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       time_valid;
  logic       frame_error;
  logic       range_error;

  int  n_tests;
  int  n_fail;
  int  n_tv;
  int  n_fe;
  int  n_re;
  time t_start;
  time t_tv;
  time t_fe;
  time t_bad;
  logic [4:0] cap_h [16];
  logic [5:0] cap_m [16];
  logic [5:0] cap_s [16];

  uart_clock_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .time_valid  (time_valid),
    .frame_error (frame_error),
    .range_error (range_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (time_valid) begin
      cap_h[n_tv[3:0]] = hours;
      cap_m[n_tv[3:0]] = minutes;
      cap_s[n_tv[3:0]] = seconds;
      n_tv = n_tv + 1;
      t_tv = $time;
    end
    if (frame_error) begin
      n_fe = n_fe + 1;
      t_fe = $time;
    end
    if (range_error) begin
      n_re = n_re + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called and returns on a negedge so consecutive calls are back to back.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx      = 1'b0;
    t_start = $time;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], 1'b1);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, 32'(hours), 32'(h));
    check({tag, "_m"}, 32'(minutes), 32'(m));
    check({tag, "_s"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_tv    = 0;
    n_fe    = 0;
    n_re    = 0;
    t_start = 0;
    t_tv    = 0;
    t_fe    = 0;
    t_bad   = 0;
    reset   = 1'b1;
    rx      = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check_time("rst", 0, 0, 0);
    check("rst_tv", 32'(time_valid), 0);
    check("rst_fe", 32'(frame_error), 0);
    check("rst_re", 32'(range_error), 0);
    reset = 1'b0;
    idle(5);

    // Basic line and strobe latency
    send_line("12:34:56\r\n");
    idle(2 * CPB);
    check("l1_ntv", n_tv, 1);
    check_time("l1", 12, 34, 56);
    check("l1_lat", 32'((t_tv - t_start) / 10), LAT_TV);

    // Back-to-back lines with no idle gap
    send_line("23:59:59\r\n");
    send_line("00:00:00\r\n");
    idle(2 * CPB);
    check("b2b_ntv", n_tv, 3);
    check("b2b_cap_h", 32'(cap_h[1]), 23);
    check("b2b_cap_m", 32'(cap_m[1]), 59);
    check("b2b_cap_s", 32'(cap_s[1]), 59);
    check_time("b2b", 0, 0, 0);

    // 20-cycle glitch is shorter than half a bit and must be ignored
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(2 * CPB);
    send_line("01:02:03\r\n");
    idle(2 * CPB);
    check("gl_ntv", n_tv, 4);
    check("gl_nfe", n_fe, 0);
    check_time("gl", 1, 2, 3);

    // Frame error mid-line resets the parser
    send_line("12:3");
    send_byte("4", 1'b0);
    t_bad = t_start;
    idle(3 * CPB);
    check("fe_nfe", n_fe, 1);
    check("fe_lat", 32'((t_fe - t_bad) / 10), LAT_FE);
    send_line("07:08:09\r\n");
    idle(2 * CPB);
    check("fe_ntv", n_tv, 5);
    check_time("fe", 7, 8, 9);

    // Template mismatch discards the line
    send_line("12x34:56\r\n");
    idle(2 * CPB);
    check("mm_ntv", n_tv, 5);
    check_time("mm_hold", 7, 8, 9);
    send_line("05:06:07\r\n");
    idle(2 * CPB);
    check("mm2_ntv", n_tv, 6);
    check_time("mm2", 5, 6, 7);

    // Out-of-range hour
    send_line("24:00:00\r\n");
    idle(2 * CPB);
`ifdef UART_CLOCK_RX_RANGE_CHECK_EN
    check("rng_nre", n_re, 1);
    check("rng_ntv", n_tv, 6);
    check_time("rng", 5, 6, 7);
`else
    check("rng_nre", n_re, 0);
    check("rng_ntv", n_tv, 7);
    check_time("rng", 24, 0, 0);
    send_line("99:00:00\r\n");
    idle(2 * CPB);
    check("trunc_ntv", n_tv, 8);
    check("trunc_h", 32'(hours), 3);
`endif

    // Reset mid-line and mid-byte
    send_line("1");
    rx = 1'b0;
    repeat (CPB + CPB / 2) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_time("mid_rst", 0, 0, 0);
    idle(2 * CPB);
    send_line("12:34:56\r\n");
    idle(2 * CPB);
`ifdef UART_CLOCK_RX_RANGE_CHECK_EN
    check("post_rst_ntv", n_tv, 7);
`else
    check("post_rst_ntv", n_tv, 9);
`endif
    check_time("post_rst", 12, 34, 56);
    check("end_nfe", n_fe, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
